rgb_pwm_fader: RTL and testbench

- Downstream consumer of the SPI RGB receiver. Takes latched 8-bit R/G/B targets plus a one-cycle valid strobe, and drives three LED PWM pins.
- Ramps each channel linearly from its current duty to the new target, so colour changes never glitch mid-period.
- Runs entirely in the 48 MHz system clock domain.

---
 rtl/rgb_pwm_fader.sv | 154 +++++++++++++++
 tb/tb_rgb_pwm_fader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_fader.sv
// Three-channel LED PWM driver that fades each duty linearly toward a latched target.
// Define RGB_PWM_GAMMA_EN to pass duties through an approximate gamma-2.0 curve.

module rgb_pwm_fader_chan #(
    parameter bit JUMP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic       step,
    input  logic       wrap,
    input  logic [7:0] din,
    input  logic [7:0] cnt,
    output logic       pend,
    output logic       pwm
);
    logic [7:0] tgt;
    logic [7:0] cur;
    logic [7:0] sh;
    logic [7:0] cur_nx;
    logic [7:0] tgt_nx;
    logic [7:0] duty;

    // A step always works against the target held before this edge.
    always_comb begin
        cur_nx = cur;
        if (step) begin
            if (JUMP)
                cur_nx = tgt;
            else if (cur < tgt)
                cur_nx = cur + 8'd1;
            else if (cur > tgt)
                cur_nx = cur - 8'd1;
        end
    end

    assign tgt_nx = valid ? din : tgt;
    assign pend   = (cur_nx != tgt_nx);

`ifdef RGB_PWM_GAMMA_EN
    logic [15:0] sq;
    assign sq   = {8'd0, cur_nx} * {8'd0, cur_nx} + {8'd0, cur_nx};
    assign duty = sq[15:8];
`else
    assign duty = cur_nx;
`endif

    // Shadow loads only at the period boundary so a period never changes duty mid-way.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt <= '0;
            cur <= '0;
            sh  <= '0;
            pwm <= 1'b0;
        end else begin
            tgt <= tgt_nx;
            cur <= cur_nx;
            if (wrap)
                sh <= duty;
            pwm <= (cnt < sh);
        end
    end
endmodule

module rgb_pwm_fader #(
    parameter int CLK_DIV  = 4,
    parameter int FADE_DIV = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_red,
    input  logic [7:0] i_green,
    input  logic [7:0] i_blue,
    input  logic       i_valid,
    output logic       o_pwm_r,
    output logic       o_pwm_g,
    output logic       o_pwm_b,
    output logic       o_busy,
    output logic       o_period
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(CLK_DIV - 1);
    localparam logic [FW-1:0] FLAST = (FADE_DIV > 0) ? FW'(FADE_DIV - 1) : '0;

    typedef enum logic {IDLE, FADING} state_t;

    state_t            state;
    state_t            state_nx;
    logic [PW-1:0]     pre;
    logic [7:0]        cnt;
    logic [FW-1:0]     fcnt;
    logic              tick;
    logic              wrap;
    logic              step;
    logic [2:0]        pend;
    logic [2:0]        pwm;
    logic [2:0][7:0]   din;

    assign tick = (pre == PLAST);
    assign wrap = tick && (cnt == 8'd255);
    assign step = (state == FADING) && wrap && ((FADE_DIV == 0) || (fcnt == FLAST));
    assign din  = {i_blue, i_green, i_red};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|pend)  state_nx = FADING;
            FADING:  if (!(|pend)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pre      <= '0;
            cnt      <= '0;
            fcnt     <= '0;
            state    <= IDLE;
            o_busy   <= 1'b0;
            o_period <= 1'b0;
        end else begin
            pre      <= tick ? '0 : pre + PW'(1);
            if (tick)
                cnt <= cnt + 8'd1;
            o_period <= wrap;
            state    <= state_nx;
            o_busy   <= (state_nx == FADING);
            // Fade counter only runs while fading and restarts on every entry.
            if (state_nx == IDLE)
                fcnt <= '0;
            else if (state == FADING && wrap)
                fcnt <= (fcnt == FLAST) ? '0 : fcnt + FW'(1);
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_ch
        rgb_pwm_fader_chan #(.JUMP(FADE_DIV == 0)) u_ch (
            .clk   (i_clk),
            .rst   (i_rst),
            .valid (i_valid),
            .step  (step),
            .wrap  (wrap),
            .din   (din[c]),
            .cnt   (cnt),
            .pend  (pend[c]),
            .pwm   (pwm[c])
        );
    end

    assign o_pwm_r = pwm[0];
    assign o_pwm_g = pwm[1];
    assign o_pwm_b = pwm[2];
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader: three instances (fade, jump, default dividers).
module tb_rgb_pwm_fader;
    logic            clk;
    logic [2:0]      rst;
    logic [2:0]      vld;
    logic [2:0][7:0] rr;
    logic [2:0][7:0] gg;
    logic [2:0][7:0] bb;
    logic [2:0]      pr, pg, pb, busy, per;

    int nchk = 0;
    int nerr = 0;

    logic [255:0] vr, vg, vb;
    logic         bs;
    logic [3:0]   acc;
    int           t;

    int lin_exp[6]  = '{0, 1, 1, 2, 2, 3};
    int rt_exp[12]  = '{3, 3, 4, 4, 5, 5, 4, 4, 3, 3, 2, 2};
    int mix_r[5]    = '{11, 11, 10, 10, 9};
    int mix_g[5]    = '{10, 10, 9, 9, 8};
    int mix_b[5]    = '{9, 9, 8, 8, 7};

    rgb_pwm_fader #(.CLK_DIV(1), .FADE_DIV(2)) dut_a (
        .i_clk(clk), .i_rst(rst[0]), .i_red(rr[0]), .i_green(gg[0]), .i_blue(bb[0]),
        .i_valid(vld[0]), .o_pwm_r(pr[0]), .o_pwm_g(pg[0]), .o_pwm_b(pb[0]),
        .o_busy(busy[0]), .o_period(per[0]));

    rgb_pwm_fader #(.CLK_DIV(1), .FADE_DIV(0)) dut_b (
        .i_clk(clk), .i_rst(rst[1]), .i_red(rr[1]), .i_green(gg[1]), .i_blue(bb[1]),
        .i_valid(vld[1]), .o_pwm_r(pr[1]), .o_pwm_g(pg[1]), .o_pwm_b(pb[1]),
        .o_busy(busy[1]), .o_period(per[1]));

    rgb_pwm_fader dut_c (
        .i_clk(clk), .i_rst(rst[2]), .i_red(rr[2]), .i_green(gg[2]), .i_blue(bb[2]),
        .i_valid(vld[2]), .o_pwm_r(pr[2]), .o_pwm_g(pg[2]), .o_pwm_b(pb[2]),
        .o_busy(busy[2]), .o_period(per[2]));

    always #5 clk = ~clk;

    function automatic int duty_of(input int c);
`ifdef RGB_PWM_GAMMA_EN
        return (c * c + c) >> 8;
`else
        return c;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for a period pulse, then record the 256 PWM samples of that period
    // (sample i reflects count i). Optionally pulse valid before the edge at count inj.
    task automatic grab(input int d, input int inj, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, output logic [255:0] vr_o, output logic [255:0] vg_o,
                        output logic [255:0] vb_o, output logic bs_o);
        int tw = 0;
        vr_o = '0; vg_o = '0; vb_o = '0;
        while (per[d] !== 1'b1 && tw < 3000) begin
            @(negedge clk);
            tw++;
        end
        chk("period_seen", 32'(per[d]), 32'd1);
        bs_o = busy[d];
        for (int i = 0; i < 256; i++) begin
            if (i == inj) begin
                vld[d] = 1'b1; rr[d] = r; gg[d] = g; bb[d] = b;
            end
            @(negedge clk);
            vld[d] = 1'b0;
            vr_o[i] = pr[d];
            vg_o[i] = pg[d];
            vb_o[i] = pb[d];
        end
    endtask

    initial begin
        clk = 1'b0; rst = '1; vld = '0; rr = '0; gg = '0; bb = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk("reset_outputs", 32'({pr[d], pg[d], pb[d], busy[d], per[d]}), 32'd0);
        rst = '0;

        // Reset in the middle of a fade toward full white
        grab(0, 10, 8'hFF, 8'hFF, 8'hFF, vr, vg, vb, bs);
        grab(0, -1, 8'h00, 8'h00, 8'h00, vr, vg, vb, bs);
        grab(0, -1, 8'h00, 8'h00, 8'h00, vr, vg, vb, bs);
        chk("prefade_duty", $countones(vr), duty_of(1));
        repeat (100) @(negedge clk);
        chk("prerst_busy", 32'(busy[0]), 32'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("rst_next_cycle", 32'({pr[0], pg[0], pb[0], busy[0], per[0]}), 32'd0);
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        acc = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            acc = acc | {pr[0], pg[0], pb[0], busy[0]};
        end
        chk("rst_dark_period", 32'(acc), 32'd0);

        // Linear fade 0 -> 3 on red
        repeat (40) @(negedge clk);
        chk("lin_busy_before", 32'(busy[0]), 32'd0);
        vld[0] = 1'b1; rr[0] = 8'd3; gg[0] = 8'd0; bb[0] = 8'd0;
        @(negedge clk);
        vld[0] = 1'b0;
        chk("lin_busy_rise", 32'(busy[0]), 32'd1);
        for (int k = 0; k < 6; k++) begin
            grab(0, -1, 8'd0, 8'd0, 8'd0, vr, vg, vb, bs);
            chk("lin_red", $countones(vr), duty_of(lin_exp[k]));
            chk("lin_green", $countones(vg), 0);
            if (k == 4) chk("lin_busy_p5", 32'(bs), 32'd1);
            if (k == 5) chk("lin_busy_p6", 32'(bs), 32'd0);
        end

        // Retarget from 0x10 down to 0x02 when red reaches 5
        for (int k = 0; k < 12; k++) begin
            grab(0, (k == 0 || k == 4) ? 100 : -1, (k == 0) ? 8'h10 : 8'h02, 8'd0, 8'd0,
                 vr, vg, vb, bs);
            chk("rt_red", $countones(vr), duty_of(rt_exp[k]));
            if (k == 9) chk("rt_busy_s9", 32'(bs), 32'd1);
            if (k >= 10) chk("rt_busy_done", 32'(bs), 32'd0);
        end

        // Mixed directions with a valid landing exactly on the step edge
        grab(0, 100, 8'd10, 8'd10, 8'd10, vr, vg, vb, bs);
        chk("mix_setup_red", $countones(vr), duty_of(2));
        t = 0;
        while (busy[0] && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("mix_settled", 32'(busy[0]), 32'd0);
        grab(0, 100, 8'd12, 8'd10, 8'd8, vr, vg, vb, bs);
        chk("mix_t0_r", $countones(vr), duty_of(10));
        chk("mix_t0_b", $countones(vb), duty_of(10));
        grab(0, 255, 8'd0, 8'd0, 8'd0, vr, vg, vb, bs);
        chk("mix_t1_g", $countones(vg), duty_of(10));
        for (int k = 0; k < 5; k++) begin
            grab(0, -1, 8'd0, 8'd0, 8'd0, vr, vg, vb, bs);
            chk("mix_r", $countones(vr), duty_of(mix_r[k]));
            chk("mix_g", $countones(vg), duty_of(mix_g[k]));
            chk("mix_b", $countones(vb), duty_of(mix_b[k]));
        end

        // Immediate update (no fade)
        grab(1, 100, 8'h10, 8'h20, 8'h30, vr, vg, vb, bs);
        chk("imm_u0_r", $countones(vr), 0);
        grab(1, -1, 8'd0, 8'd0, 8'd0, vr, vg, vb, bs);
        chk("imm_u1_r", $countones(vr), duty_of(16));
        chk("imm_u1_g", $countones(vg), duty_of(32));
        chk("imm_u1_b", $countones(vb), duty_of(48));
        grab(1, 100, 8'h40, 8'h00, 8'hFF, vr, vg, vb, bs);
        chk("imm_hold_r", $countones(vr), duty_of(16));
        chk("imm_hold_b", $countones(vb), duty_of(48));
        grab(1, 100, 8'd128, 8'd16, 8'd255, vr, vg, vb, bs);
        chk("imm_busy_clear", 32'(bs), 32'd0);
        chk("imm_r", $countones(vr), duty_of(64));
        chk("imm_g", $countones(vg), 0);
        chk("imm_b", $countones(vb), duty_of(255));
        chk("imm_r_first", 32'(vr[0]), 32'd1);
        chk("imm_r_last_hi", 32'(vr[duty_of(64) - 1]), 32'd1);
        chk("imm_r_fall", 32'(vr[duty_of(64)]), 32'd0);
        chk("imm_b_254", 32'(vb[254]), 32'd1);
        chk("imm_b_255", 32'(vb[255]), 32'd0);
        grab(1, -1, 8'd0, 8'd0, 8'd0, vr, vg, vb, bs);
        chk("gam_r", $countones(vr), duty_of(128));
        chk("gam_g", $countones(vg), duty_of(16));
        chk("gam_b", $countones(vb), duty_of(255));

        // Default dividers: period is 256*4 clocks, pulse is one cycle wide
        t = 0;
        while (per[2] !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("c_pulse_width", 32'(per[2]), 32'd0);
        t = 1;
        while (per[2] !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("c_period_len", 32'(t), 32'd1024);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
